// File: rtl/maze_wall_map_if.sv
// maze_wall_map_if: query bus between a sprite mover and the maze wall lookup; door_open exists only with GHOST_DOOR_EN
interface maze_wall_map_if;
  logic [9:0] x;
  logic [8:0] y;
  logic       isWall;
`ifdef GHOST_DOOR_EN
  logic       door_open;
  modport master(output x, y, door_open, input isWall);
  modport slave(input x, y, door_open, output isWall);
`else
  modport master(output x, y, input isWall);
  modport slave(input x, y, output isWall);
`endif
endinterface

// File: rtl/maze_wall_map.sv
// maze_wall_map: registered pixel-to-wall lookup for the Pac-Man maze; GHOST_DOOR_EN adds a passable ghost-house door
module maze_wall_map #(
  parameter int TILE_SHIFT = 4,
  parameter int H_PIXELS   = 640,
  parameter int V_PIXELS   = 480
) (
  input logic            clk,
  input logic            rst_n,
  maze_wall_map_if.slave bus
);
  localparam logic [9:0] X_END    = 10'(H_PIXELS);
  localparam logic [8:0] Y_END    = 9'(V_PIXELS);
  localparam logic [9:0] LAST_COL = 10'((H_PIXELS >> TILE_SHIFT) - 1);
  localparam logic [8:0] LAST_ROW = 9'((V_PIXELS >> TILE_SHIFT) - 1);
  logic [9:0] col;
  logic [8:0] row;
  logic       out_of_range, border, door, perimeter, interior, pillar, door_wall, wall;
  assign col = bus.x >> TILE_SHIFT;
  assign row = bus.y >> TILE_SHIFT;
`ifdef GHOST_DOOR_EN
  assign door_wall = !bus.door_open;
`else
  assign door_wall = 1'b1;
`endif
  // Tile classification, resolved in priority order so the house interior beats the pillar lattice
  always_comb begin
    out_of_range = bus.x >= X_END || bus.y >= Y_END;
    border       = col == 10'd0 || col == LAST_COL || row == 9'd0 || row == LAST_ROW;
    door         = row == 9'd13 && (col == 10'd19 || col == 10'd20);
    perimeter    = row >= 9'd13 && row <= 9'd16 && col >= 10'd17 && col <= 10'd22 &&
                   (row == 9'd13 || row == 9'd16 || col == 10'd17 || col == 10'd22);
    interior     = row >= 9'd14 && row <= 9'd15 && col >= 10'd18 && col <= 10'd21;
    pillar       = col[1:0] == 2'b11 && row[1:0] == 2'b11;
    wall         = out_of_range ? 1'b1 : border ? 1'b1 : door ? door_wall :
                   perimeter ? 1'b1 : interior ? 1'b0 : pillar;
  end
  // Single output flop; reset reports blocked until the first real lookup
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.isWall <= 1'b1;
    else        bus.isWall <= wall;
endmodule

// File: tb/tb_maze_wall_map.sv
// tb_maze_wall_map: scoreboard bench for maze_wall_map against a painted 40x30 tile map
module tb_maze_wall_map;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maze_wall_map_if bus();
  maze_wall_map dut(.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit w;
    int px;
    int py;
  } exp_t;

  exp_t exp_q[$];
  bit   tile_map[40][30];
  int   checks = 0;
  int   errors = 0;
  bit   door_sig = 1'b0;

  // Paint the maze layer by layer, lowest priority first, later layers overwrite earlier ones
  function automatic void paint_map();
    for (int c = 0; c < 40; c++)
      for (int r = 0; r < 30; r++) begin
        tile_map[c][r] = (c % 4 == 3) && (r % 4 == 3);
        if (r >= 14 && r <= 15 && c >= 18 && c <= 21) tile_map[c][r] = 0;
        if (r >= 13 && r <= 16 && c >= 17 && c <= 22 && (r == 13 || r == 16 || c == 17 || c == 22))
          tile_map[c][r] = 1;
        if (c == 0 || c == 39 || r == 0 || r == 29) tile_map[c][r] = 1;
      end
  endfunction

  function automatic bit ref_wall(int px, int py);
    int c = px / 16;
    int r = py / 16;
    if (px >= 640 || py >= 480) return 1'b1;
`ifdef GHOST_DOOR_EN
    if (r == 13 && (c == 19 || c == 20)) return !door_sig;
`endif
    return tile_map[c][r];
  endfunction

  task automatic query(int px, int py, bit d);
    exp_t e;
    @(negedge clk);
    bus.x = 10'(px);
    bus.y = 9'(py);
    door_sig = d;
`ifdef GHOST_DOOR_EN
    bus.door_open = d;
`endif
    e.w = ref_wall(px, py);
    e.px = px;
    e.py = py;
    exp_q.push_back(e);
  endtask

  // Monitor: one result per cycle, compared against the oldest outstanding query
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.isWall !== e.w) begin
        errors++;
        $display("FAIL query(%0d,%0d): isWall=%b expected %b", e.px, e.py, bus.isWall, e.w);
      end
    end
  end

  initial begin
    exp_t e;
    paint_map();
    bus.x = 10'd200;
    bus.y = 9'd146;
`ifdef GHOST_DOOR_EN
    bus.door_open = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.isWall !== 1'b1) begin
      errors++;
      $display("FAIL reset: isWall=%b expected 1", bus.isWall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e.w = ref_wall(200, 146);
    e.px = 200;
    e.py = 146;
    exp_q.push_back(e);
    query(0, 0, 0);
    query(639, 479, 0);
    query(640, 100, 0);
    query(1023, 50, 0);
    query(16, 16, 0);
    query(56, 56, 0);
    query(63, 63, 0);
    query(64, 56, 0);
    query(200, 130, 0);
    query(272, 224, 0);
    query(304, 240, 0);
    query(352, 256, 0);
    for (int i = 0; i < 6; i++) query((i % 2) ? 200 : 56, (i % 2) ? 146 : 56, 0);
    query(304, 208, 0);
    query(304, 208, 1);
    query(336, 208, 1);
    query(336, 208, 0);
    query(320, 223, 1);
    for (int i = 0; i < 400; i++)
      query(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 200; i++)
      query(int'($urandom_range(256, 367)), int'($urandom_range(192, 271)), 1'($urandom_range(0, 1)));
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
